// File: rtl/rdm_combine_scheduler.sv
// rdm_combine_scheduler
// Walks the code blocks of a rate-dematching combine job: for each CB it
// presents index, E size, Ncb and the input-buffer base word, pulses a
// request to the RDM and waits for its completion before moving on.
// Optional watchdog on the RDM wait: define RDM_SCHED_TIMEOUT_EN.
module rdm_combine_scheduler #(
    parameter int WORD_LLRS = 16
) (
    input  logic        i_core_clk,
    input  logic        i_rx_rstn,
    input  logic        i_rx_fsm_rstn,
    input  logic        i_Start,
    input  logic [5:0]  i_CB_Num,
    input  logic [5:0]  i_E1_Start_Index,
    input  logic [13:0] i_E0_Size,
    input  logic [13:0] i_E1_Size,
    input  logic [15:0] i_Ncb_Size,
    input  logic [15:0] i_Start_Address,
    input  logic        i_RDM_Data_Comp,
    output logic        o_Combine_process_request,
    output logic [13:0] o_Current_Combine_E01_Size,
    output logic [15:0] o_Current_Combine_Ncb_Size,
    output logic [15:0] o_CB_Base_Address,
    output logic [5:0]  o_CB_Index,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Timeout_Err
);

    // Rounding constants for ceil(E / WORD_LLRS) in 16-bit arithmetic;
    // 14-bit E plus a small rounding term cannot overflow 16 bits.
    localparam logic [15:0] LLR_DIV = 16'(WORD_LLRS);
    localparam logic [15:0] LLR_RND = 16'(WORD_LLRS - 1);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_LOAD = 6'b000010,
        S_REQ  = 6'b000100,
        S_WAIT = 6'b001000,
        S_NEXT = 6'b010000,
        S_DONE = 6'b100000
    } state_t;

    state_t      state_q;

    // Job configuration captured on an accepted start
    logic [5:0]  cb_num_q;
    logic [5:0]  e1_start_q;
    logic [13:0] e0_q;
    logic [13:0] e1_q;
    logic [15:0] ncb_q;

    // Per-CB progress, also driven straight onto the data outputs
    logic [5:0]  idx_q;
    logic [15:0] base_q;
    logic [13:0] e01_q;

    logic        req_q;
    logic        done_q;
    logic        busy_q;

`ifdef RDM_SCHED_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        tmo_q;
`endif

    // Values the NEXT state commits for the following CB
    logic [15:0] words_d;
    logic [15:0] base_d;
    logic [5:0]  idx_d;
    logic [13:0] e01_d;

    // Advance arithmetic: base moves by the words the current CB occupies
    always_comb begin
        words_d = (16'(e01_q) + LLR_RND) / LLR_DIV;
        base_d  = base_q + words_d;
        idx_d   = idx_q + 6'd1;
        e01_d   = (idx_d >= e1_start_q) ? e1_q : e0_q;
    end

    // Scheduler FSM; E size is resolved on entry to LOAD so the data
    // outputs are already valid while LOAD is current
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q    <= S_IDLE;
            cb_num_q   <= '0;
            e1_start_q <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
            ncb_q      <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            e01_q      <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RDM_SCHED_TIMEOUT_EN
            wdog_q     <= '0;
            tmo_q      <= 1'b0;
`endif
        end else if (!i_rx_fsm_rstn) begin
            // Soft abort: the timeout flag survives until the next start
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RDM_SCHED_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_Start) begin
                        cb_num_q   <= i_CB_Num;
                        e1_start_q <= i_E1_Start_Index;
                        e0_q       <= i_E0_Size;
                        e1_q       <= i_E1_Size;
                        ncb_q      <= i_Ncb_Size;
                        idx_q      <= '0;
                        base_q     <= i_Start_Address;
                        e01_q      <= (i_E1_Start_Index == 6'd0) ? i_E1_Size : i_E0_Size;
                        busy_q     <= 1'b1;
`ifdef RDM_SCHED_TIMEOUT_EN
                        tmo_q      <= 1'b0;
`endif
                        state_q    <= (i_CB_Num == 6'd0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
`ifdef RDM_SCHED_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_RDM_Data_Comp) begin
                        state_q <= S_NEXT;
`ifdef RDM_SCHED_TIMEOUT_EN
                    end else if (wdog_q == 16'hFFFF) begin
                        tmo_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wdog_q  <= wdog_q + 16'd1;
`endif
                    end
                end
                S_NEXT: begin
                    base_q  <= base_d;
                    idx_q   <= idx_d;
                    e01_q   <= e01_d;
                    state_q <= (idx_d == cb_num_q) ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Combine_process_request  = req_q;
    assign o_Current_Combine_E01_Size = e01_q;
    assign o_Current_Combine_Ncb_Size = ncb_q;
    assign o_CB_Base_Address          = base_q;
    assign o_CB_Index                 = idx_q;
    assign o_Busy                     = busy_q;
    assign o_Done                     = done_q;
`ifdef RDM_SCHED_TIMEOUT_EN
    assign o_Timeout_Err              = tmo_q;
`else
    assign o_Timeout_Err              = 1'b0;
`endif

endmodule

// File: tb/tb_rdm_combine_scheduler.sv
// Self-checking bench for rdm_combine_scheduler: table vectors, randomized
// jobs against a per-CB list model, and hand sequences for the corner cases.
module tb_rdm_combine_scheduler;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rstn, fsm_rstn, start, comp;
    logic [5:0]  cb_num, e1s;
    logic [13:0] e0, e1;
    logic [15:0] ncb, sa;
    logic        req, busy, done, tmo;
    logic [13:0] eo;
    logic [15:0] ncbo, baseo;
    logic [5:0]  idxo;

    always #5 clk = ~clk;

    rdm_combine_scheduler #(.WORD_LLRS(W)) dut (
        .i_core_clk(clk), .i_rx_rstn(rstn), .i_rx_fsm_rstn(fsm_rstn),
        .i_Start(start), .i_CB_Num(cb_num), .i_E1_Start_Index(e1s),
        .i_E0_Size(e0), .i_E1_Size(e1), .i_Ncb_Size(ncb), .i_Start_Address(sa),
        .i_RDM_Data_Comp(comp), .o_Combine_process_request(req),
        .o_Current_Combine_E01_Size(eo), .o_Current_Combine_Ncb_Size(ncbo),
        .o_CB_Base_Address(baseo), .o_CB_Index(idxo), .o_Busy(busy),
        .o_Done(done), .o_Timeout_Err(tmo)
    );

    typedef struct { int idx; int base; int e; int ncb; } rq_t;
    typedef struct { int cb; int e1s; int e0; int e1; int ncb; int sa;
                     int n_req; int last_base; int last_e; } vec_t;

    rq_t  obs[$];
    rq_t  exp_q[$];
    int   done_cnt = 0;
    int   n_chk = 0, n_err = 0;
    vec_t tbl[7];

    // Observer: every request pulse with the data presented alongside it
    always @(negedge clk) begin
        rq_t r;
        if (req === 1'b1) begin
            r.idx = int'(idxo); r.base = int'(baseo); r.e = int'(eo); r.ncb = int'(ncbo);
            obs.push_back(r);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: list of CBs with E chosen by index and bases as running
    // sums of word counts, wrapped to 16 bits
    task automatic build_model(input int c, input int s, input int a0, input int a1,
                               input int n, input int ad);
        int base;
        rq_t r;
        exp_q.delete();
        base = ad;
        for (int i = 0; i < c; i++) begin
            r.idx = i; r.base = base; r.e = (i >= s) ? a1 : a0; r.ncb = n;
            exp_q.push_back(r);
            base = (base + (r.e + W - 1) / W) % 65536;
        end
    endtask

    task automatic set_cfg(input int c, input int s, input int a0, input int a1,
                           input int n, input int ad);
        cb_num = 6'(c); e1s = 6'(s); e0 = 14'(a0); e1 = 14'(a1); ncb = 16'(n); sa = 16'(ad);
    endtask

    task automatic wait_req(input string nm, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (req === 1'b1) ok = 1'b1;
        end
        if (!ok) chk({nm, " req_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_job(input string nm, input int c, input int s, input int a0,
                           input int a1, input int n, input int ad, input bit inject,
                           output int nreq, output int lbase, output int le);
        int o0, d0, k;
        bit fin;
        build_model(c, s, a0, a1, n, ad);
        o0 = obs.size(); d0 = done_cnt;
        set_cfg(c, s, a0, a1, n, ad);
        start = 1'b1; tick(); start = 1'b0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            if (done === 1'b1) begin
                fin = 1'b1;
                chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
            end else if (req === 1'b1) begin
                if (inject) begin
                    inject = 1'b0;
                    tick();
                    set_cfg(5, 0, 7, 7, 1, 16'h4000);
                    start = 1'b1; tick(); start = 1'b0;
                end else begin
                    repeat ($urandom_range(4, 1)) tick();
                end
                comp = 1'b1; tick(); comp = 1'b0;
            end else begin
                tick();
            end
        end
        if (!fin) chk({nm, " done_timeout"}, 32'd0, 32'd1);
        tick(); tick();
        chk({nm, " done_count"}, 32'(done_cnt - d0), 32'd1);
        nreq = obs.size() - o0;
        chk({nm, " req_count"}, 32'(nreq), 32'(exp_q.size()));
        k = (nreq < exp_q.size()) ? nreq : exp_q.size();
        for (int i = 0; i < k; i++) begin
            chk($sformatf("%s cb%0d idx", nm, i),  32'(obs[o0+i].idx),  32'(exp_q[i].idx));
            chk($sformatf("%s cb%0d base", nm, i), 32'(obs[o0+i].base), 32'(exp_q[i].base));
            chk($sformatf("%s cb%0d e", nm, i),    32'(obs[o0+i].e),    32'(exp_q[i].e));
            chk($sformatf("%s cb%0d ncb", nm, i),  32'(obs[o0+i].ncb),  32'(exp_q[i].ncb));
        end
        chk({nm, " tmo_clear"}, 32'(tmo), 32'd0);
        lbase = (nreq > 0) ? obs[obs.size()-1].base : 0;
        le    = (nreq > 0) ? obs[obs.size()-1].e : 0;
    endtask

    initial begin
        int nreq, lb, le, o0, d0;
        bit ok, fin;

        //           cb e1s   e0     e1    ncb     sa    nreq lastbase laste
        tbl[0] = '{3, 1,  100,   120, 16'h1234, 0,       3, 15,      120};
        tbl[1] = '{2, 0,  100,   100, 16'h0800, 16'hFFFE, 2, 16'h0005, 100};
        tbl[2] = '{0, 0,  50,    60,  16'h0010, 16'h0100, 0, 0,       0};
        tbl[3] = '{1, 5,  16,    200, 16'hFFFF, 16'h0100, 1, 16'h0100, 16};
        tbl[4] = '{4, 2,  1,     17,  16'h0001, 10,      4, 14,      17};
        tbl[5] = '{2, 63, 16383, 0,   16'h8000, 16'hFFF0, 2, 16'h03F0, 16383};
        tbl[6] = '{3, 1,  32,    0,   16'h0002, 0,       3, 2,       0};

        rstn = 1'b0; fsm_rstn = 1'b1; start = 1'b0; comp = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst req",  32'(req),   32'd0);
        chk("rst busy", 32'(busy),  32'd0);
        chk("rst done", 32'(done),  32'd0);
        chk("rst tmo",  32'(tmo),   32'd0);
        chk("rst base", 32'(baseo), 32'd0);
        chk("rst idx",  32'(idxo),  32'd0);
        chk("rst e",    32'(eo),    32'd0);
        chk("rst ncb",  32'(ncbo),  32'd0);
        rstn = 1'b1;
        tick();

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            run_job($sformatf("vec%0d", i), tbl[i].cb, tbl[i].e1s, tbl[i].e0, tbl[i].e1,
                    tbl[i].ncb, tbl[i].sa, 1'b0, nreq, lb, le);
            chk($sformatf("vec%0d nreq", i), 32'(nreq), 32'(tbl[i].n_req));
            if (tbl[i].n_req > 0) begin
                chk($sformatf("vec%0d last_base", i), 32'(lb), 32'(tbl[i].last_base));
                chk($sformatf("vec%0d last_e", i),    32'(le), 32'(tbl[i].last_e));
            end
        end

        // Randomized jobs against the list model
        for (int j = 0; j < 20; j++) begin
            run_job($sformatf("rnd%0d", j), int'($urandom_range(6, 1)), int'($urandom_range(7, 0)),
                    int'($urandom_range(16383, 0)), int'($urandom_range(16383, 0)),
                    int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0)),
                    1'b0, nreq, lb, le);
        end

        // Zero-CB job: done two cycles after start, no request
        o0 = obs.size(); d0 = done_cnt;
        set_cfg(0, 0, 10, 10, 1, 16'h0200);
        start = 1'b1; tick(); start = 1'b0;
        chk("cb0 done_c1", 32'(done), 32'd0);
        chk("cb0 busy_c1", 32'(busy), 32'd1);
        tick();
        chk("cb0 done_c2", 32'(done), 32'd1);
        chk("cb0 busy_c2", 32'(busy), 32'd0);
        tick();
        chk("cb0 done_c3", 32'(done), 32'd0);
        chk("cb0 reqs", 32'(obs.size() - o0), 32'd0);

        // Completion while idle changes nothing
        o0 = obs.size(); d0 = done_cnt;
        comp = 1'b1; tick(); comp = 1'b0;
        repeat (3) tick();
        chk("idle_comp busy", 32'(busy), 32'd0);
        chk("idle_comp reqs", 32'(obs.size() - o0), 32'd0);
        chk("idle_comp done", 32'(done_cnt - d0), 32'd0);

        // Start pulse during WAIT is ignored; job completes as first configured
        run_job("start_in_wait", 2, 1, 40, 90, 16'h0333, 16'h1000, 1'b1, nreq, lb, le);

        // Soft reset during WAIT of CB 1 aborts the job
        o0 = obs.size(); d0 = done_cnt;
        set_cfg(3, 1, 100, 120, 16'h0055, 16'h0020);
        start = 1'b1; tick(); start = 1'b0;
        wait_req("fsmrst r0", ok);
        tick(); comp = 1'b1; tick(); comp = 1'b0;
        wait_req("fsmrst r1", ok);
        if (ok) chk("fsmrst idx1", 32'(idxo), 32'd1);
        tick();
        fsm_rstn = 1'b0; tick(); fsm_rstn = 1'b1;
        chk("fsmrst busy", 32'(busy), 32'd0);
        chk("fsmrst req",  32'(req),  32'd0);
        comp = 1'b1; tick(); comp = 1'b0;
        repeat (10) tick();
        chk("fsmrst reqs", 32'(obs.size() - o0), 32'd2);
        chk("fsmrst done", 32'(done_cnt - d0), 32'd0);
        chk("fsmrst busy_hold", 32'(busy), 32'd0);
        run_job("after_fsmrst", 2, 1, 64, 65, 16'h0777, 16'h0040, 1'b0, nreq, lb, le);

`ifdef RDM_SCHED_TIMEOUT_EN
        // Watchdog: no completion after the request
        o0 = obs.size(); d0 = done_cnt;
        set_cfg(2, 0, 100, 100, 16'h0100, 0);
        start = 1'b1; tick(); start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 70000 && !fin; c++) begin
            tick();
            if (done === 1'b1) fin = 1'b1;
        end
        chk("tmo done_seen", 32'(fin), 32'd1);
        chk("tmo err", 32'(tmo), 32'd1);
        chk("tmo reqs", 32'(obs.size() - o0), 32'd1);
        repeat (5) tick();
        chk("tmo done_once", 32'(done_cnt - d0), 32'd1);
        chk("tmo sticky", 32'(tmo), 32'd1);
        run_job("after_tmo", 1, 0, 16, 16, 16'h0001, 16'h0008, 1'b0, nreq, lb, le);
`else
        chk("tmo tied", 32'(tmo), 32'd0);
`endif

        // Asynchronous reset mid-job clears outputs without a clock edge
        set_cfg(2, 0, 100, 100, 16'h0ABC, 16'h0300);
        start = 1'b1; tick(); start = 1'b0;
        wait_req("arst", ok);
        tick();
        rstn = 1'b0;
        #1;
        chk("arst busy", 32'(busy),  32'd0);
        chk("arst base", 32'(baseo), 32'd0);
        chk("arst ncb",  32'(ncbo),  32'd0);
        chk("arst e",    32'(eo),    32'd0);
        tick();
        rstn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rdm_combine_scheduler.md
RDM_COMBINE_SCHEDULER -- requirements
Module: rdm_combine_scheduler

Interface
REQ-001 SHALL have parameter WORD_LLRS, default 16, meaning LLRs packed per 96-bit input-buffer word.
REQ-002 SHALL have port i_core_clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rx_rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_rx_fsm_rstn, input, 1, synchronous active-low FSM soft reset.
REQ-005 SHALL have port i_Start, input, 1, one-cycle pulse that starts a job.
REQ-006 SHALL have port i_CB_Num, input, 6, number of code blocks in the job, 0..63.
REQ-007 SHALL have port i_E1_Start_Index, input, 6, first CB index that uses the E1 size.
REQ-008 SHALL have ports i_E0_Size and i_E1_Size, input, 14 each, E0 and E1 sizes in LLRs.
REQ-009 SHALL have port i_Ncb_Size, input, 16, circular-buffer size passed to the RDM.
REQ-010 SHALL have port i_Start_Address, input, 16, input-buffer word address of CB 0.
REQ-011 SHALL have port i_RDM_Data_Comp, input, 1, RDM completion pulse for the current CB.
REQ-012 SHALL have port o_Combine_process_request, output, 1, one-cycle request pulse to the RDM.
REQ-013 SHALL have port o_Current_Combine_E01_Size, output, 14, E size of the current CB.
REQ-014 SHALL have port o_Current_Combine_Ncb_Size, output, 16, latched Ncb.
REQ-015 SHALL have port o_CB_Base_Address, output, 16, input-buffer base word of the current CB.
REQ-016 SHALL have port o_CB_Index, output, 6, index of the current CB.
REQ-017 SHALL have ports o_Busy, output, 1; o_Done, output, 1, one-cycle pulse; o_Timeout_Err, output, 1, sticky.

Function
REQ-018 SHALL implement a one-hot FSM with states IDLE, LOAD, REQ, WAIT, NEXT and DONE.
REQ-019 SHALL, in IDLE on i_Start, latch CB_Num, E0, E1, E1_Start_Index, Ncb and Start_Address, set index=0 and base=Start_Address, and go to LOAD; if CB_Num=0 it SHALL go to DONE instead, issuing no request.
REQ-020 SHALL, in LOAD, drive E01_Size = (index >= E1_Start_Index) ? E1 : E0, and go to REQ.
REQ-021 SHALL, in REQ, assert o_Combine_process_request for exactly one cycle, then go to WAIT.
REQ-022 SHALL, in WAIT, go to NEXT on the cycle after i_RDM_Data_Comp is sampled high.
REQ-023 SHALL, in NEXT, compute base += ceil(E01_Size/WORD_LLRS) modulo 2^16 and index += 1; it SHALL go to DONE if the new index equals CB_Num, else to LOAD.
REQ-024 SHALL, in DONE, pulse o_Done for one cycle and return to IDLE.
REQ-025 SHALL ignore i_Start outside IDLE and ignore i_RDM_Data_Comp outside WAIT.
REQ-026 SHALL hold o_Busy high in every state except IDLE.
REQ-027 SHALL keep the data outputs stable from LOAD until NEXT.

Reset
REQ-028 SHALL, when i_rx_rstn is low, asynchronously force IDLE and drive every output and counter to 0.
REQ-029 SHALL, when i_rx_fsm_rstn is low at a clock edge, force IDLE and clear the request, o_Done and o_Busy, aborting any job in flight; o_Timeout_Err SHALL be cleared only by i_rx_rstn or by the next accepted i_Start.

Configuration
REQ-030 SHALL, with RDM_SCHED_TIMEOUT_EN defined, run a 16-bit watchdog in WAIT that is cleared on WAIT entry; on reaching 0xFFFF without i_RDM_Data_Comp it SHALL set o_Timeout_Err and go to DONE.
REQ-031 SHALL, without RDM_SCHED_TIMEOUT_EN, omit the watchdog; WAIT SHALL then wait indefinitely and o_Timeout_Err SHALL be tied to 0.

Verification
REQ-032 SHALL cover: CB_Num=3, E0=100, E1=120, E1_Start=1, Start_Address=0 -> three request pulses, with bases 0, 7 and 15, E sizes 100, 120 and 120, and one o_Done pulse.
REQ-033 SHALL cover: Start_Address=0xFFFE, CB_Num=2, E0=E1=100 -> the second base is 0x0005 (wrap-around).
REQ-034 SHALL cover: CB_Num=0 with i_Start -> o_Done pulses 2 cycles after i_Start, with zero requests.
REQ-035 SHALL cover: i_Start pulse during WAIT, and i_RDM_Data_Comp during IDLE -> no state change and no extra request.
REQ-036 SHALL cover: i_rx_fsm_rstn low for one cycle during WAIT of CB 1 -> IDLE next cycle, o_Busy=0, and a new i_Start is accepted.
REQ-037 SHALL cover, with RDM_SCHED_TIMEOUT_EN: no i_RDM_Data_Comp for 65535 cycles after the request -> o_Timeout_Err=1, and o_Done pulses once.
